// File: rtl/edge_detector_core.sv
// edge_detector_core
// Bus-mastering edge-detection engine. On an accepted start request it walks
// the source image pixel by pixel, reads the centre, right and down
// neighbours, and writes 0xFF where |r-c| + |d-c| exceeds THRESH, else 0x00.
// Pixels in the last column or last row are written 0x00 after reading only
// the centre pixel.
//
// Ports
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   req             : start request (level); a held-high req starts one job
//   ack             : one-cycle pulse when a request is accepted
//   busy            : high while a job is running
//   de_req/de_ack   : memory transfer handshake; completes when both are high
//   de_addr         : word address
//   de_nbyte        : one-hot byte-lane select
//   de_rnw          : 1 = read, 0 = write
//   de_w_data       : write data (edge byte replicated on all lanes)
//   de_r_data       : read data, sampled on the completing edge
module edge_detector_core #(
    parameter int unsigned IMG_W    = 16,
    parameter int unsigned IMG_H    = 16,
    parameter logic [17:0] SRC_BASE = 18'h00000,
    parameter logic [17:0] DST_BASE = 18'h01000,
    parameter logic [7:0]  THRESH   = 8'd32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    output logic        ack,
    output logic        busy,
    output logic        de_req,
    input  logic        de_ack,
    output logic [17:0] de_addr,
    output logic [3:0]  de_nbyte,
    output logic        de_rnw,
    output logic [31:0] de_w_data,
    input  logic [31:0] de_r_data
);

    localparam int unsigned AW = 18;
    localparam int unsigned DW = 32;
    localparam int unsigned XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    typedef enum logic [2:0] {
        IDLE,
        RD_C,
        RD_R,
        RD_D,
        WR,
        NEXT,
        FIN
    } state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [7:0]      c_q, c_d;
    logic [7:0]      r_q, r_d;
    logic            armed_q, armed_d;
    logic            ack_q, ack_d;
    logic            busy_q, busy_d;
    logic            de_req_q, de_req_d;
    logic [AW-1:0]   de_addr_q, de_addr_d;
    logic [3:0]      de_nbyte_q, de_nbyte_d;
    logic            de_rnw_q, de_rnw_d;
    logic [DW-1:0]   de_w_data_q, de_w_data_d;

    // Byte offsets of the centre, right and down pixels of the current position
    logic [AW-1:0]   off_c;
    logic [AW-1:0]   off_r;
    logic [AW-1:0]   off_d;
    logic            last_col;
    logic            last_row;
    logic            border;
    logic            xfer_done;
    logic [7:0]      rd_byte;
    logic [8:0]      grad;
    logic [7:0]      edge_pix;

    // Byte of a read word selected by the one-hot lane of the current transfer
    function automatic logic [7:0] pick_lane(input logic [DW-1:0] w, input logic [3:0] oh);
        logic [7:0] b;
        case (oh)
            4'b0001: b = w[7:0];
            4'b0010: b = w[15:8];
            4'b0100: b = w[23:16];
            4'b1000: b = w[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    function automatic logic [8:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        return (a >= b) ? 9'(a - b) : 9'(b - a);
    endfunction

    function automatic logic [AW-1:0] word_addr(input logic [AW-1:0] base, input logic [AW-1:0] off);
        return base + (off >> 2);
    endfunction

    function automatic logic [3:0] lane_sel(input logic [AW-1:0] off);
        return 4'b0001 << off[1:0];
    endfunction

    // Pixel geometry and the gradient of the pixel being finished
    assign off_c     = AW'(y_q) * AW'(IMG_W) + AW'(x_q);
    assign off_r     = off_c + AW'(1);
    assign off_d     = off_c + AW'(IMG_W);
    assign last_col  = (x_q == XW'(IMG_W - 1));
    assign last_row  = (y_q == YW'(IMG_H - 1));
    assign border    = last_col | last_row;
    assign xfer_done = de_req_q & de_ack;
    assign rd_byte   = pick_lane(de_r_data, de_nbyte_q);
    // In RD_D the down pixel is on the bus this cycle; c and r are already held
    assign grad      = abs_diff(r_q, c_q) + abs_diff(rd_byte, c_q);
    assign edge_pix  = (grad > {1'b0, THRESH}) ? 8'hFF : 8'h00;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            c_q         <= '0;
            r_q         <= '0;
            armed_q     <= 1'b1;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            de_req_q    <= 1'b0;
            de_addr_q   <= '0;
            de_nbyte_q  <= '0;
            de_rnw_q    <= 1'b1;
            de_w_data_q <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            c_q         <= c_d;
            r_q         <= r_d;
            armed_q     <= armed_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            de_req_q    <= de_req_d;
            de_addr_q   <= de_addr_d;
            de_nbyte_q  <= de_nbyte_d;
            de_rnw_q    <= de_rnw_d;
            de_w_data_q <= de_w_data_d;
        end
    end

    // Next-state and next-output logic; a completing transfer directly
    // launches the following one so de_req stays high within a pixel
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        c_d         = c_q;
        r_d         = r_q;
        ack_d       = 1'b0;
        busy_d      = busy_q;
        de_req_d    = de_req_q;
        de_addr_d   = de_addr_q;
        de_nbyte_d  = de_nbyte_q;
        de_rnw_d    = de_rnw_q;
        de_w_data_d = de_w_data_q;
        // A low req re-arms; only an accepted start disarms
        armed_d     = armed_q | ~req;

        case (state_q)
            IDLE: begin
                busy_d     = 1'b0;
                de_req_d   = 1'b0;
                de_nbyte_d = 4'b0000;
                de_rnw_d   = 1'b1;
                if (req && armed_q) begin
                    ack_d   = 1'b1;
                    armed_d = 1'b0;
                    x_d     = '0;
                    y_d     = '0;
                    state_d = RD_C;
                end
            end

            RD_C: begin
                if (!de_req_q) begin
                    busy_d     = 1'b1;
                    de_req_d   = 1'b1;
                    de_addr_d  = word_addr(SRC_BASE, off_c);
                    de_nbyte_d = lane_sel(off_c);
                    de_rnw_d   = 1'b1;
                end else if (xfer_done) begin
                    c_d = rd_byte;
                    if (border) begin
                        state_d     = WR;
                        de_addr_d   = word_addr(DST_BASE, off_c);
                        de_nbyte_d  = lane_sel(off_c);
                        de_rnw_d    = 1'b0;
                        de_w_data_d = '0;
                    end else begin
                        state_d    = RD_R;
                        de_addr_d  = word_addr(SRC_BASE, off_r);
                        de_nbyte_d = lane_sel(off_r);
                        de_rnw_d   = 1'b1;
                    end
                end
            end

            RD_R: begin
                if (xfer_done) begin
                    r_d        = rd_byte;
                    state_d    = RD_D;
                    de_addr_d  = word_addr(SRC_BASE, off_d);
                    de_nbyte_d = lane_sel(off_d);
                    de_rnw_d   = 1'b1;
                end
            end

            RD_D: begin
                if (xfer_done) begin
                    state_d     = WR;
                    de_addr_d   = word_addr(DST_BASE, off_c);
                    de_nbyte_d  = lane_sel(off_c);
                    de_rnw_d    = 1'b0;
                    de_w_data_d = {4{edge_pix}};
                end
            end

            WR: begin
                if (xfer_done) begin
                    state_d    = NEXT;
                    de_req_d   = 1'b0;
                    de_nbyte_d = 4'b0000;
                    de_rnw_d   = 1'b1;
                end
            end

            NEXT: begin
                if (last_col) begin
                    x_d = '0;
                    if (last_row) begin
                        state_d = FIN;
                    end else begin
                        y_d     = y_q + YW'(1);
                        state_d = RD_C;
                    end
                end else begin
                    x_d     = x_q + XW'(1);
                    state_d = RD_C;
                end
            end

            FIN: begin
                busy_d     = 1'b0;
                de_req_d   = 1'b0;
                de_nbyte_d = 4'b0000;
                de_rnw_d   = 1'b1;
                state_d    = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ack       = ack_q;
    assign busy      = busy_q;
    assign de_req    = de_req_q;
    assign de_addr   = de_addr_q;
    assign de_nbyte  = de_nbyte_q;
    assign de_rnw    = de_rnw_q;
    assign de_w_data = de_w_data_q;

endmodule

// File: tb/tb_edge_detector_core.sv
// Bench for edge_detector_core: frame memory slave with optional random
// de_ack latency, a pixel-level reference of the edge image, and directed
// plus randomized source images.
module tb_edge_detector_core;

    localparam int W = 16;
    localparam int H = 16;
    localparam int N = W * H;
    localparam logic [17:0] SRC = 18'h00000;
    localparam logic [17:0] DST = 18'h01000;
    localparam int THR = 32;

    typedef struct packed {
        logic [17:0] addr;
        logic [3:0]  nbyte;
        logic [31:0] data;
    } xfer_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        ack;
    logic        busy;
    logic        de_req;
    logic        de_ack = 1'b1;
    logic [17:0] de_addr;
    logic [3:0]  de_nbyte;
    logic        de_rnw;
    logic [31:0] de_w_data;
    logic [31:0] de_r_data;

    edge_detector_core #(
        .IMG_W(W), .IMG_H(H), .SRC_BASE(SRC), .DST_BASE(DST), .THRESH(8'(THR))
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .ack(ack), .busy(busy),
        .de_req(de_req), .de_ack(de_ack), .de_addr(de_addr), .de_nbyte(de_nbyte),
        .de_rnw(de_rnw), .de_w_data(de_w_data), .de_r_data(de_r_data)
    );

    always #5 clk = ~clk;

    logic [7:0]  src_img [N];
    logic [7:0]  got_img [N];
    logic [7:0]  fast_img [N];
    logic [17:0] got_addr [N];
    logic [3:0]  got_nb [N];

    int n_vec = 0;
    int n_err = 0;

    // Source memory: read word assembled from the byte image
    int rd_idx;
    always_comb begin
        rd_idx    = (int'(de_addr) - int'(SRC)) * 4;
        de_r_data = 32'h0;
        if (rd_idx >= 0 && rd_idx < N)
            de_r_data = {src_img[rd_idx + 3], src_img[rd_idx + 2], src_img[rd_idx + 1], src_img[rd_idx]};
    end

    // Bus slave / monitor, evaluated mid-cycle so it sees what the next rising edge will see
    bit          slow = 1'b0;
    int          ack_wait = 0;
    int          ack_cnt, busy_falls, ack_busy_err, wr_idle_err, stab_err;
    bit          prev_ack, prev_busy, pend;
    logic [54:0] saved_bus;
    xfer_t       rd_q[$];
    xfer_t       wr_q[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            pend      = 1'b0;
            prev_ack  = 1'b0;
            prev_busy = 1'b0;
            ack_wait  = 0;
            de_ack    = !slow;
        end else begin
            if (!slow)
                de_ack = 1'b1;
            else if (!de_req)
                de_ack = 1'($urandom_range(0, 1));
            else if (ack_wait > 0) begin
                de_ack   = 1'b0;
                ack_wait = ack_wait - 1;
            end else
                de_ack = 1'b1;

            if (pend && de_req && ({de_addr, de_nbyte, de_rnw, de_w_data} !== saved_bus))
                stab_err++;
            if (de_req && de_ack) begin
                if (de_rnw)
                    rd_q.push_back('{de_addr, de_nbyte, 32'h0});
                else begin
                    wr_q.push_back('{de_addr, de_nbyte, de_w_data});
                    if (!busy) wr_idle_err++;
                end
                ack_wait = $urandom_range(0, 3);
            end
            pend      = de_req && !de_ack;
            saved_bus = {de_addr, de_nbyte, de_rnw, de_w_data};

            if (ack) begin
                ack_cnt++;
                if (busy) ack_busy_err++;
            end
            if (prev_ack && !busy) ack_busy_err++;
            if (prev_busy && !busy) busy_falls++;
            prev_ack  = ack;
            prev_busy = busy;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: edge byte of pixel p from the source image
    function automatic logic [7:0] ref_pix(input int p);
        int x, y, c, r, d, g;
        x = p % W;
        y = p / W;
        if (x == W - 1 || y == H - 1) return 8'h00;
        c = int'(src_img[p]);
        r = int'(src_img[p + 1]);
        d = int'(src_img[p + W]);
        g = (r > c ? r - c : c - r) + (d > c ? d - c : c - d);
        return (g > THR) ? 8'hFF : 8'h00;
    endfunction

    task automatic run_job(input bit pulse);
        int t;
        ack_cnt = 0; busy_falls = 0; ack_busy_err = 0; wr_idle_err = 0; stab_err = 0;
        rd_q.delete();
        wr_q.delete();
        @(negedge clk);
        req = 1'b1;
        t = 0;
        @(negedge clk);
        while (ack !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("ack_seen", 32'(ack), 32'd1);
        if (pulse) begin
            @(negedge clk);
            req = 1'b0;
        end
        @(negedge clk);
        t = 0;
        while (busy !== 1'b0 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check("busy_fall", 32'(busy), 32'd0);
        repeat (10) @(negedge clk);
        req = 1'b0;
        repeat (3) @(negedge clk);
        check("ack_count", 32'(ack_cnt), 32'd1);
        check("busy_falls", 32'(busy_falls), 32'd1);
        check("ack_busy_seq", 32'(ack_busy_err), 32'd0);
        check("write_while_idle", 32'(wr_idle_err), 32'd0);
    endtask

    task automatic check_job(input string tag);
        xfer_t t;
        int    x, y, nr, off;
        int    offs[3];
        logic [7:0] e;
        for (int p = 0; p < N; p++) begin
            x = p % W;
            y = p / W;
            nr = (x == W - 1 || y == H - 1) ? 1 : 3;
            offs[0] = p; offs[1] = p + 1; offs[2] = p + W;
            for (int k = 0; k < nr; k++) begin
                check($sformatf("%s_rd_present_p%0d", tag, p), 32'(rd_q.size() != 0), 32'd1);
                if (rd_q.size() == 0) return;
                t   = rd_q.pop_front();
                off = offs[k];
                check($sformatf("%s_rd_p%0d_k%0d", tag, p, k), 32'({t.addr, t.nbyte}),
                      32'({SRC + 18'(off / 4), 4'(1 << (off % 4))}));
            end
            check($sformatf("%s_wr_present_p%0d", tag, p), 32'(wr_q.size() != 0), 32'd1);
            if (wr_q.size() == 0) return;
            t = wr_q.pop_front();
            e = ref_pix(p);
            check($sformatf("%s_wr_p%0d", tag, p), 32'({t.addr, t.nbyte}),
                  32'({DST + 18'(p / 4), 4'(1 << (p % 4))}));
            check($sformatf("%s_wdata_p%0d", tag, p), t.data, {4{e}});
            got_img[p]  = t.data[8 * (p % 4) +: 8];
            got_addr[p] = t.addr;
            got_nb[p]   = t.nbyte;
        end
        check($sformatf("%s_extra_reads", tag), 32'(rd_q.size()), 32'd0);
        check($sformatf("%s_extra_writes", tag), 32'(wr_q.size()), 32'd0);
    endtask

    initial begin
        int diffs, ones;
        rst_n = 1'b0;
        req   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_de_req", 32'(de_req), 32'd0);
        check("rst_de_addr", 32'(de_addr), 32'd0);
        check("rst_de_nbyte", 32'(de_nbyte), 32'd0);
        check("rst_de_rnw", 32'(de_rnw), 32'd1);
        check("rst_de_w_data", de_w_data, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // All-zero source, req held high, de_ack tied high
        for (int i = 0; i < N; i++) src_img[i] = 8'h00;
        run_job(1'b0);
        check_job("zero");

        // Single bright pixel at (3,3)
        src_img[3 * W + 3] = 8'h80;
        run_job(1'b0);
        check_job("dot");
        check("dot_2_3", 32'(got_img[3 * W + 2]), 32'hFF);
        check("dot_3_2", 32'(got_img[2 * W + 3]), 32'hFF);
        check("dot_3_3", 32'(got_img[3 * W + 3]), 32'hFF);
        check("dot_3_3_nbyte", 32'(got_nb[3 * W + 3]), 32'b1000);
        check("dot_3_3_addr", 32'(got_addr[3 * W + 3]), 32'(DST + 18'd12));
        ones = 0;
        for (int i = 0; i < N; i++) if (got_img[i] == 8'hFF) ones++;
        check("dot_ones", 32'(ones), 32'd3);

        // Gradient exactly at and just above the threshold
        for (int i = 0; i < N; i++) src_img[i] = 8'h00;
        src_img[5 * W + 6] = 8'd32;
        run_job(1'b0);
        check_job("thr32");
        check("thr32_5_5", 32'(got_img[5 * W + 5]), 32'h00);
        src_img[5 * W + 6] = 8'd33;
        run_job(1'b0);
        check_job("thr33");
        check("thr33_5_5", 32'(got_img[5 * W + 5]), 32'hFF);

        // Smooth random image: fast memory, then slow memory, same result
        for (int i = 0; i < N; i++) src_img[i] = 8'($urandom_range(100, 140));
        run_job(1'b0);
        check_job("rnd_fast");
        for (int i = 0; i < N; i++) fast_img[i] = got_img[i];
        slow = 1'b1;
        run_job(1'b0);
        check_job("rnd_slow");
        check("slow_stable", 32'(stab_err), 32'd0);
        diffs = 0;
        for (int i = 0; i < N; i++) if (got_img[i] !== fast_img[i]) diffs++;
        check("slow_vs_fast", 32'(diffs), 32'd0);

        // Full-range random image with slow memory
        for (int i = 0; i < N; i++) src_img[i] = 8'($urandom_range(0, 255));
        run_job(1'b0);
        check_job("full_slow");
        check("full_slow_stable", 32'(stab_err), 32'd0);
        slow = 1'b0;

        // Reset mid-job, then restart with a req pulse
        @(negedge clk);
        req = 1'b1;
        repeat (100) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_de_req", 32'(de_req), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ack", 32'(ack), 32'd0);
        check("midrst_nbyte", 32'(de_nbyte), 32'd0);
        check("midrst_rnw", 32'(de_rnw), 32'd1);
        check("midrst_addr", 32'(de_addr), 32'd0);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_job(1'b1);
        check_job("restart");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
